// File: rtl/uart_bus_master_if.sv
// Bus-ownership handshake and address/strobe lines shared by the UART bridge
// and the SoC peripheral bus. The bidirectional data lines stay on the top-level port.
interface uart_bus_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;

  modport master (output bus_req, output mem_we, output mem_addr, input bus_gnt);
  modport slave  (input bus_req, input mem_we, input mem_addr, output bus_gnt);
endinterface

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: decodes 8N1 command frames, runs one 32-bit bus cycle
// per frame after arbitration, and reports the result back over UART.
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 208,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              busy,
  inout  wire  [31:0]       mem_data,
  uart_bus_master_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_CNT  = TMO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, ACCESS, RESP} cmd_state_t;

  logic [2:0]       rx_sync_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid, rx_ferr, rx_in;

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_sh_q, tx_sh_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_load, tx_done;

  cmd_state_t       state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d, resp_q, resp_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d, resp_left_q, resp_left_d;
  logic             resp_sent_q, resp_sent_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // [1] is the synchronized line, [2] its previous value for edge detection
  assign rx_in = rx_sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q[2] && !rx_in) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_CNT) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_CNT) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_in, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_CNT) begin
        rx_valid   = rx_in;
        rx_ferr    = !rx_in;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_out_d   = tx_out_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_out_d = 1'b1;
        if (tx_load) begin
          tx_state_d = TX_SHIFT;
          tx_sh_d    = {1'b1, resp_q[31:24]};
          tx_bit_d   = '0;
          tx_out_d   = 1'b0;
        end
      end
      TX_SHIFT: if (tx_cnt_q == BIT_CNT) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_done    = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_out_d = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    byte_cnt_d  = byte_cnt_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    resp_sent_d = resp_sent_q;
    tmo_d       = '0;
    tx_load     = 1'b0;
    case (state_q)
      IDLE: begin
        byte_cnt_d  = '0;
        resp_left_d = '0;
        resp_sent_d = 1'b0;
        if (rx_ferr) begin
          resp_d  = {8'h21, 24'h0};
          state_d = RESP;
        end else if (rx_valid) begin
          if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
            op_wr_d = (rx_sh_q == 8'h57);
            state_d = ADDR;
          end else begin
            resp_d  = {8'h3F, 24'h0};
            state_d = RESP;
          end
        end
      end
      ADDR, DATA: begin
        tmo_d = tmo_q + 1'b1;
        if (rx_ferr) begin
          resp_d      = {8'h21, 24'h0};
          resp_left_d = '0;
          resp_sent_d = 1'b0;
          state_d     = RESP;
        end else if (rx_valid) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (state_q == ADDR) addr_d = {addr_q[23:0], rx_sh_q};
          else                 data_d = {data_q[23:0], rx_sh_q};
          if (byte_cnt_q == 2'd3) state_d = (state_q == ADDR && op_wr_q) ? DATA : REQ;
        end else if (tmo_q == TMO_CNT) begin
          state_d = IDLE;
        end
      end
      REQ: if (bus.bus_gnt) state_d = ACCESS;
      ACCESS: begin
        // Read data is captured at the edge that closes the access cycle
        resp_d      = op_wr_q ? {8'h4B, 24'h0} : mem_data;
        resp_left_d = op_wr_q ? 2'd0 : 2'd3;
        resp_sent_d = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (!resp_sent_q && tx_state_q == TX_IDLE) begin
          tx_load     = 1'b1;
          resp_sent_d = 1'b1;
        end
        if (tx_done) begin
          resp_d      = {resp_q[23:0], 8'h0};
          resp_left_d = resp_left_q - 1'b1;
          resp_sent_d = 1'b0;
          if (resp_left_q == 2'd0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q   <= 3'b111;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_out_q    <= 1'b1;
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      byte_cnt_q  <= '0;
      resp_left_q <= '0;
      resp_sent_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      rx_sync_q   <= {rx_sync_q[1:0], uart_rx};
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_out_q    <= tx_out_d;
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_q      <= resp_d;
      byte_cnt_q  <= byte_cnt_d;
      resp_left_q <= resp_left_d;
      resp_sent_q <= resp_sent_d;
      tmo_q       <= tmo_d;
    end
  end

  // Bus outputs decode straight from the registered state, so reset clears them at once
  assign bus.bus_req  = (state_q == REQ) || (state_q == ACCESS);
  assign bus.mem_we   = (state_q == ACCESS) && op_wr_q;
  assign bus.mem_addr = (state_q == ACCESS) ? addr_q : 32'h0;
  assign mem_data     = bus.mem_we ? data_q : 32'bz;
  assign busy         = (state_q != IDLE);
  assign uart_tx      = tx_out_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: scoreboarded UART responses and bus accesses.
module tb_uart_bus_master;
  localparam int CPB      = 16;
  localparam int TMO_BITS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        busy;
  wire  [31:0] mem_data;
  logic [31:0] rd_val;

  uart_bus_master_if bus_if ();

  uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .mem_data (mem_data),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  // Combinational read responder
  assign rd_val   = (bus_if.mem_addr == 32'hFFFF0020) ? 32'hDEADBEEF
                  : {bus_if.mem_addr[15:0], ~bus_if.mem_addr[15:0]};
  assign mem_data = (!bus_if.mem_we && bus_if.mem_addr != 32'h0) ? rd_val : 32'bz;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic [7:0] exp_tx[$];
  acc_t       exp_acc[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         req_cnt = 0;
  logic       mon_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    exp_acc.push_back('{we: 1'b1, addr: a, data: d});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(a);
    send_word(d);
  endtask

  task automatic send_read(input logic [31:0] a, input logic [31:0] d, input logic push_tx);
    exp_acc.push_back('{we: 1'b0, addr: a, data: 32'h0});
    if (push_tx) for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    send_byte(8'h52, 1'b1);
    send_word(a);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 4000 && busy; k++) @(negedge clk);
    chk(tag, 32'(busy), 32'h0);
  endtask

  // UART transmit monitor: decodes each byte mid-bit and pops the scoreboard
  initial begin : tx_mon
    logic [7:0]  b;
    logic        st, sp;
    logic [31:0] ew;
    forever begin
      @(negedge clk);
      if (rst && !uart_tx) begin
        repeat (CPB / 2) @(negedge clk);
        st = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        sp = uart_tx;
        if (mon_en) begin
          if (exp_tx.size() != 0) ew = {22'h0, 1'b0, 1'b1, exp_tx.pop_front()};
          else                    ew = 32'hFFFF_FFFF;
          chk("tx_byte", {22'h0, st, sp, b}, ew);
        end
      end
    end
  end

  // Bus monitor: every owned cycle must match the next expected access
  initial begin : bus_mon
    acc_t e;
    forever begin
      @(negedge clk);
      if (bus_if.bus_req) req_cnt++;
      if (bus_if.mem_we || bus_if.mem_addr != 32'h0) begin
        if (exp_acc.size() != 0) e = exp_acc.pop_front();
        else                     e = '0;
        chk("acc_we", 32'(bus_if.mem_we), 32'(e.we));
        chk("acc_addr", bus_if.mem_addr, e.addr);
        chk("acc_req", 32'(bus_if.bus_req), 32'h1);
        if (e.we) chk("acc_data", mem_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int   req_before;
    logic seen;
    bus_if.bus_gnt = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'h1);
    chk("rst_req", 32'(bus_if.bus_req), 32'h0);
    chk("rst_we", 32'(bus_if.mem_we), 32'h0);
    chk("rst_addr", bus_if.mem_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Write with grant tied high
    send_write(32'hFFFF0028, 32'h12345678);
    wait_idle("t1_idle");

    // Reads
    send_read(32'hFFFF0020, 32'hDEADBEEF, 1'b1);
    wait_idle("t2_idle");
    send_read(32'h00A51234, 32'h1234EDCB, 1'b1);
    wait_idle("t2b_idle");

    // Grant withheld for 50 cycles
    bus_if.bus_gnt = 1'b0;
    send_write(32'h00000100, 32'hA5A55A5A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        chk("t3_req", 32'(bus_if.bus_req), 32'h1);
        chk("t3_we", 32'(bus_if.mem_we), 32'h0);
        chk("t3_addr", bus_if.mem_addr, 32'h0);
      end
    end
    bus_if.bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_access_we", 32'(bus_if.mem_we), 32'h1);
    chk("t3_access_addr", bus_if.mem_addr, 32'h00000100);
    wait_idle("t3_idle");

    // Unknown opcode, then a short glitch
    req_before = req_cnt;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41, 1'b1);
    wait_idle("t4_idle");
    chk("t4_no_req", 32'(req_cnt), 32'(req_before));
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    uart_rx = 1'b1;
    seen = 1'b0;
    repeat (25 * CPB) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("t4_glitch", 32'(seen), 32'h0);

    // Framing error on the third byte of a write
    req_before = req_cnt;
    exp_tx.push_back(8'h21);
    send_byte(8'h57, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    wait_idle("t5_idle");
    chk("t5_no_req", 32'(req_cnt), 32'(req_before));
    send_write(32'h00000200, 32'h0F1E2D3C);
    wait_idle("t5b_idle");

    // Inter-byte timeout
    send_byte(8'h57, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("t6_busy_mid", 32'(busy), 32'h1);
    seen = 1'b0;
    repeat (70 * CPB) begin
      @(negedge clk);
      if (!uart_tx) seen = 1'b1;
    end
    chk("t6_busy_after", 32'(busy), 32'h0);
    chk("t6_tx_quiet", 32'(seen), 32'h0);

    // Asynchronous reset during the response
    mon_en = 1'b0;
    send_read(32'hFFFF0020, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 2000 && uart_tx; k++) @(negedge clk);
    repeat (CPB / 4) @(negedge clk);
    chk("t7_pre_tx", 32'(uart_tx), 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("t7_tx", 32'(uart_tx), 32'h1);
    chk("t7_req", 32'(bus_if.bus_req), 32'h0);
    chk("t7_we", 32'(bus_if.mem_we), 32'h0);
    chk("t7_addr", bus_if.mem_addr, 32'h0);
    chk("t7_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15 * CPB) begin
      @(negedge clk);
      if (!uart_tx) seen = 1'b1;
    end
    chk("t7_tx_quiet", 32'(seen), 32'h0);
    mon_en = 1'b1;

    send_write(32'h00000300, 32'h55AA00FF);
    wait_idle("t8_idle");
    repeat (4) @(negedge clk);
    chk("sb_tx_empty", 32'(exp_tx.size()), 32'h0);
    chk("sb_acc_empty", 32'(exp_acc.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/loader bridge: a host PC drives 32-bit reads and writes on the SoC peripheral/memory bus over a UART link.
- Receives 8N1 command frames on uart_rx and executes each as a single bus cycle as bus initiator.
- Reuses the mem_we / mem_addr / inout mem_data bus that the peripherals respond on, and returns results on uart_tx.
- Arbitrates with the CPU through a bus_req/bus_gnt handshake.

Parameters:
- CLKS_PER_BIT, 208, clock cycles per UART bit; must be at least 4.
- TIMEOUT_BITS, 64, maximum gap between bytes of one frame, in bit-times, before the frame is abandoned.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- uart_rx  input  1  serial in; idle high; asynchronous to clk.
- uart_tx  output  1  serial out, 8N1, idle high.
- bus_req  output  1  request for bus ownership.
- bus_gnt  input  1  bus granted by the arbiter.
- mem_we  output  1  write strobe; high only during an owned write cycle.
- mem_addr  output  32  bus address; 0 when the bus is not owned.
- mem_data  inout  32  driven only while mem_we=1, otherwise high-Z; sampled on reads.
- busy  output  1  high whenever the command FSM is not in IDLE.

Behaviour:
Reset values:
- rst low asynchronously forces: uart_tx=1, bus_req=0, mem_we=0, mem_addr=0, mem_data=Z, busy=0.
- All counters and shift registers clear; FSM goes to IDLE.
- Reset mid-frame or mid-transmit aborts with no further output.

RX path:
- uart_rx passes through a 2-flop synchronizer; both flops reset to 1.
- In RX_IDLE, a falling edge starts a counter. At CLKS_PER_BIT/2 the start bit is re-sampled; if it is high, the event is a glitch and RX returns to RX_IDLE.
- 8 data bits are then sampled LSB first, each CLKS_PER_BIT cycles after the previous sample.
- The stop bit is sampled likewise. Stop=1 produces a one-cycle rx_valid carrying the byte. Stop=0 produces a one-cycle rx_ferr.

TX path:
- A one-cycle tx_load accepts a byte only when the TX engine is idle.
- Output sequence: start (0), 8 data bits LSB first, stop (1), each held exactly CLKS_PER_BIT cycles.
- tx_done pulses at the end of the stop bit.

Command frame (multi-byte fields MSB first):
- Write: 0x57, A3 A2 A1 A0, D3 D2 D1 D0.
- Read: 0x52, A3 A2 A1 A0.

FSM states: IDLE, ADDR, DATA, REQ, ACCESS, RESP.
- IDLE, byte 0x57 or 0x52: latch opcode, go to ADDR.
- IDLE, any other byte: queue response 0x3F, go to RESP.
- ADDR: shift in 4 bytes. Then a write goes to DATA; a read goes to REQ.
- DATA: shift in 4 bytes, then go to REQ.
- REQ: bus_req=1; wait for bus_gnt with no timeout. On the first edge where bus_req and bus_gnt are both high, go to ACCESS.
- ACCESS, exactly one cycle:
  - mem_addr = latched address.
  - For a write: mem_we=1 and mem_data = latched data.
  - For a read: mem_we=0, and mem_data is captured at the closing clock edge (the responder is combinational).
  - bus_req stays high during ACCESS.
  - Next cycle: bus_req=0, mem_addr=0, mem_data=Z.
  - Then go to RESP.
- RESP:
  - A write sends 0x4B.
  - A read sends the captured word as 4 bytes, MSB first.
  - Go to IDLE on tx_done of the last byte.

Error and boundary rules:
- rx_ferr in IDLE, ADDR or DATA: discard the partial frame, send 0x21, return to IDLE.
- Inter-byte timer: counts cycles since the last rx_valid while in ADDR or DATA. If it reaches TIMEOUT_BITS*CLKS_PER_BIT, silently return to IDLE with no response.
- Bytes or framing errors arriving in REQ, ACCESS or RESP are dropped; the RX engine keeps running.
- bus_gnt dropping while in REQ: keep waiting.
- mem_we is never high unless bus_gnt was high at the start of that cycle.

Test Plan:
1. bus_gnt tied 1; send 57 FF FF 00 28 12 34 56 78 -> exactly one cycle with mem_we=1, mem_addr=0xFFFF0028, mem_data=0x12345678; then uart_tx emits 0x4B; busy falls after its stop bit.
2. Responder returns 0xDEADBEEF at 0xFFFF0020; send 52 FF FF 00 20 -> one cycle with mem_we=0, mem_addr=0xFFFF0020; uart_tx emits DE AD BE EF, each byte bit-accurate at 208 clocks/bit.
3. bus_gnt held low 50 cycles after the write frame -> bus_req=1 throughout, mem_we=0, mem_addr=0, mem_data=Z; the access happens on the first cycle after bus_gnt rises.
4. Send 0x41 -> uart_tx emits 0x3F; bus_req never asserts. Inject a 30-cycle low glitch on idle uart_rx -> no byte decoded.
5. Force the stop bit low on the 3rd byte of a write -> uart_tx emits 0x21 with no bus access. A subsequent valid write completes normally.
6. Send 57 FF, then idle for 70 bit-times -> busy returns to 0 with no output. Separately, assert rst mid-response -> uart_tx=1 and bus outputs at reset values immediately, without waiting for a clk edge.
